// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a sticky
// illegal-instruction trap. Opcode and funct are captured in DECODE so later instr changes are ignored.
module multi_cycle_ctrl #(
    parameter logic FETCH_OP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        zero,
    output logic [1:0]  ext_op,
    output logic        ir_write,
    output logic        pc_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_b,
    output logic [2:0]  alu_ctl,
    output logic [2:0]  state,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] funct_q, funct_d;
    logic [1:0] ext_op_q, ext_op_d;
    logic       illegal_q, illegal_d;

    logic [5:0] op_in, funct_in;
    logic [1:0] ext_in;
    logic       legal_in;
    logic       unused_instr;

    assign op_in        = instr[31:26];
    assign funct_in     = instr[5:0];
    assign unused_instr = ^instr[25:6];

    // Raw decode of the live instruction; only consumed while in DECODE.
    always_comb begin
        legal_in = 1'b1;
        ext_in   = 2'b00;
        case (op_in)
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: ext_in = 2'b01;
            OP_ANDI, OP_ORI:                     ext_in = 2'b00;
            OP_LUI:                              ext_in = 2'b10;
            OP_R: begin
                ext_in = 2'b01;
                case (funct_in)
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT: legal_in = 1'b1;
                    default:                          legal_in = 1'b0;
                endcase
            end
            default: legal_in = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= 6'h00;
            funct_q   <= 6'h00;
            ext_op_q  <= 2'b00;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            funct_q   <= funct_d;
            ext_op_q  <= ext_op_d;
            illegal_q <= illegal_d;
        end
    end

    // Memory handshake: mem_read/mem_write are held as levels for the whole access;
    // the access completes in the cycle mem_ready=1, and the FSM advances on that edge.
    always_comb begin
        state_d   = S_FETCH;
        op_d      = op_q;
        funct_d   = funct_q;
        ext_op_d  = ext_op_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                op_d     = op_in;
                funct_d  = funct_in;
                ext_op_d = legal_in ? ext_in : 2'b00;
                if (legal_in) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                if (op_q == OP_BEQ || op_q == OP_J)     state_d = S_FETCH;
                else if (op_q == OP_LW || op_q == OP_SW) state_d = S_MEM;
                else                                     state_d = S_WB;
            end
            S_MEM: begin
                if (!mem_ready)         state_d = S_MEM;
                else if (op_q == OP_LW) state_d = S_WB;
                else                    state_d = S_FETCH;
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs depend on state and latched op/funct; FETCH completion and the beq
    // branch decision are the only input-dependent terms. Reset silences everything at once.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_b  = 1'b0;
        alu_ctl    = 3'b010;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_read = FETCH_OP;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_EXEC: begin
                    alu_src_b = op_q inside {OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW};
                    case (op_q)
                        OP_R: begin
                            case (funct_q)
                                F_SUB:   alu_ctl = 3'b110;
                                F_AND:   alu_ctl = 3'b000;
                                F_OR:    alu_ctl = 3'b001;
                                F_SLT:   alu_ctl = 3'b111;
                                default: alu_ctl = 3'b010;
                            endcase
                        end
                        OP_ANDI: alu_ctl = 3'b000;
                        OP_ORI:  alu_ctl = 3'b001;
                        OP_BEQ:  alu_ctl = 3'b110;
                        default: alu_ctl = 3'b010;
                    endcase
                    pc_write = (op_q == OP_J) || (op_q == OP_BEQ && zero);
                end
                S_MEM: begin
                    mem_read  = (op_q == OP_LW);
                    mem_write = (op_q == OP_SW);
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (op_q == OP_R);
                    mem_to_reg = (op_q == OP_LW);
                end
                default: ;
            endcase
        end
    end

    assign ext_op  = ext_op_q;
    assign illegal = illegal_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: walks each instruction class cycle by cycle,
// checking state, strobes and datapath controls against hand-computed values.
module tb_multi_cycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic        zero;
    logic [1:0]  ext_op;
    logic        ir_write, pc_write, mem_read, mem_write, reg_write;
    logic        reg_dst, mem_to_reg, alu_src_b;
    logic [2:0]  alu_ctl;
    logic [2:0]  state;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] ADDI = 32'h2008FFFF;
    localparam logic [31:0] ORI  = 32'h3508FFFF;
    localparam logic [31:0] LUI  = 32'h3C081234;
    localparam logic [31:0] ANDI = 32'h3108000F;
    localparam logic [31:0] SUB  = 32'h01095022;
    localparam logic [31:0] SLT  = 32'h0109502A;
    localparam logic [31:0] LW   = 32'h8D090004;
    localparam logic [31:0] SW   = 32'hAD090004;
    localparam logic [31:0] BEQ  = 32'h11090003;
    localparam logic [31:0] JMP  = 32'h08000010;
    localparam logic [31:0] BAD  = 32'hFC000000;
    localparam logic [31:0] BADF = 32'h01095021;
    localparam logic [31:0] JUNK = 32'hFFFFFFFF;

    multi_cycle_ctrl #(.FETCH_OP(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .mem_ready  (mem_ready),
        .zero       (zero),
        .ext_op     (ext_op),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_b  (alu_src_b),
        .alu_ctl    (alu_ctl),
        .state      (state),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {ir_write, pc_write, mem_read, mem_write, reg_write}
    function automatic logic [4:0] strb();
        return {ir_write, pc_write, mem_read, mem_write, reg_write};
    endfunction

    task automatic exp_cyc(input string tag, input logic [2:0] st, input logic [4:0] sb);
        chk({tag, " state"}, {29'd0, state}, {29'd0, st});
        chk({tag, " strobes"}, {27'd0, strb()}, {27'd0, sb});
    endtask

    // One cycle: drive inputs at the falling edge, sample 1ns later.
    task automatic cyc(input logic [31:0] ins, input logic mr, input logic z);
        @(negedge clk);
        rst_n     = 1'b1;
        instr     = ins;
        mem_ready = mr;
        zero      = z;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; instr = ADDI; mem_ready = 1'b1; zero = 1'b0;
        #3;
        exp_cyc("reset", 3'd0, 5'b00000);
        chk("reset ext_op", {30'd0, ext_op}, 32'd0);
        chk("reset alu_ctl", {29'd0, alu_ctl}, 32'd2);
        chk("reset illegal", {31'd0, illegal}, 32'd0);

        // addi: 0,1,2,4 then back to FETCH; instr trashed after DECODE
        cyc(ADDI, 1, 0); exp_cyc("addi c0", 3'd0, 5'b11100);
        cyc(ADDI, 1, 0); exp_cyc("addi c1", 3'd1, 5'b00000);
        cyc(JUNK, 1, 0); exp_cyc("addi c2", 3'd2, 5'b00000);
        chk("addi ext_op", {30'd0, ext_op}, 32'd1);
        chk("addi alu_src_b", {31'd0, alu_src_b}, 32'd1);
        chk("addi alu_ctl", {29'd0, alu_ctl}, 32'd2);
        cyc(JUNK, 1, 0); exp_cyc("addi c3", 3'd4, 5'b00001);
        chk("addi reg_dst", {31'd0, reg_dst}, 32'd0);
        chk("addi mem_to_reg", {31'd0, mem_to_reg}, 32'd0);
        chk("addi ext_op wb", {30'd0, ext_op}, 32'd1);

        // ori
        cyc(ORI, 1, 0); exp_cyc("ori c0", 3'd0, 5'b11100);
        chk("ori ext_op held", {30'd0, ext_op}, 32'd1);
        cyc(ORI, 1, 0); exp_cyc("ori c1", 3'd1, 5'b00000);
        cyc(ORI, 1, 0); exp_cyc("ori c2", 3'd2, 5'b00000);
        chk("ori ext_op", {30'd0, ext_op}, 32'd0);
        chk("ori alu_ctl", {29'd0, alu_ctl}, 32'd1);
        chk("ori alu_src_b", {31'd0, alu_src_b}, 32'd1);
        cyc(ORI, 1, 0); exp_cyc("ori c3", 3'd4, 5'b00001);

        // lui
        cyc(LUI, 1, 0); exp_cyc("lui c0", 3'd0, 5'b11100);
        cyc(LUI, 1, 0); exp_cyc("lui c1", 3'd1, 5'b00000);
        cyc(LUI, 1, 0); exp_cyc("lui c2", 3'd2, 5'b00000);
        chk("lui ext_op", {30'd0, ext_op}, 32'd2);
        chk("lui alu_ctl", {29'd0, alu_ctl}, 32'd2);
        cyc(LUI, 1, 0); exp_cyc("lui c3", 3'd4, 5'b00001);

        // andi
        cyc(ANDI, 1, 0); cyc(ANDI, 1, 0);
        cyc(ANDI, 1, 0); exp_cyc("andi c2", 3'd2, 5'b00000);
        chk("andi ext_op", {30'd0, ext_op}, 32'd0);
        chk("andi alu_ctl", {29'd0, alu_ctl}, 32'd0);
        cyc(ANDI, 1, 0); exp_cyc("andi c3", 3'd4, 5'b00001);

        // R-type sub
        cyc(SUB, 1, 0); exp_cyc("sub c0", 3'd0, 5'b11100);
        cyc(SUB, 1, 0); exp_cyc("sub c1", 3'd1, 5'b00000);
        cyc(SUB, 1, 0); exp_cyc("sub c2", 3'd2, 5'b00000);
        chk("sub alu_ctl", {29'd0, alu_ctl}, 32'd6);
        chk("sub alu_src_b", {31'd0, alu_src_b}, 32'd0);
        chk("sub ext_op", {30'd0, ext_op}, 32'd1);
        cyc(SUB, 1, 0); exp_cyc("sub c3", 3'd4, 5'b00001);
        chk("sub reg_dst", {31'd0, reg_dst}, 32'd1);

        // R-type slt
        cyc(SLT, 1, 0); cyc(SLT, 1, 0);
        cyc(SLT, 1, 0); chk("slt alu_ctl", {29'd0, alu_ctl}, 32'd7);
        cyc(SLT, 1, 0); exp_cyc("slt c3", 3'd4, 5'b00001);

        // lw: 2 FETCH stalls + 3 MEM stalls = 10 cycles
        cyc(LW, 0, 0); exp_cyc("lw c0", 3'd0, 5'b00100);
        cyc(LW, 0, 0); exp_cyc("lw c1", 3'd0, 5'b00100);
        cyc(LW, 1, 0); exp_cyc("lw c2", 3'd0, 5'b11100);
        cyc(LW, 1, 0); exp_cyc("lw c3", 3'd1, 5'b00000);
        cyc(LW, 1, 0); exp_cyc("lw c4", 3'd2, 5'b00000);
        chk("lw alu_src_b", {31'd0, alu_src_b}, 32'd1);
        cyc(LW, 0, 0); exp_cyc("lw c5", 3'd3, 5'b00100);
        cyc(LW, 0, 0); exp_cyc("lw c6", 3'd3, 5'b00100);
        cyc(LW, 0, 0); exp_cyc("lw c7", 3'd3, 5'b00100);
        chk("lw mem_to_reg stall", {31'd0, mem_to_reg}, 32'd0);
        cyc(LW, 1, 0); exp_cyc("lw c8", 3'd3, 5'b00100);
        cyc(LW, 1, 0); exp_cyc("lw c9", 3'd4, 5'b00001);
        chk("lw mem_to_reg", {31'd0, mem_to_reg}, 32'd1);
        chk("lw reg_dst", {31'd0, reg_dst}, 32'd0);

        // sw, 4 cycles
        cyc(SW, 1, 0); exp_cyc("sw c0", 3'd0, 5'b11100);
        cyc(SW, 1, 0); exp_cyc("sw c1", 3'd1, 5'b00000);
        cyc(SW, 1, 0); exp_cyc("sw c2", 3'd2, 5'b00000);
        chk("sw alu_src_b", {31'd0, alu_src_b}, 32'd1);
        cyc(SW, 1, 0); exp_cyc("sw c3", 3'd3, 5'b00010);

        // beq taken then not taken, 3 cycles each
        cyc(BEQ, 1, 1); exp_cyc("beqt c0", 3'd0, 5'b11100);
        cyc(BEQ, 1, 1); exp_cyc("beqt c1", 3'd1, 5'b00000);
        cyc(BEQ, 1, 1); exp_cyc("beqt c2", 3'd2, 5'b01000);
        chk("beq alu_ctl", {29'd0, alu_ctl}, 32'd6);
        chk("beq alu_src_b", {31'd0, alu_src_b}, 32'd0);
        cyc(BEQ, 1, 0); exp_cyc("beqn c0", 3'd0, 5'b11100);
        cyc(BEQ, 1, 0); exp_cyc("beqn c1", 3'd1, 5'b00000);
        cyc(BEQ, 1, 0); exp_cyc("beqn c2", 3'd2, 5'b00000);

        // j: unconditional pc_write in EXEC
        cyc(JMP, 1, 0); exp_cyc("j c0", 3'd0, 5'b11100);
        cyc(JMP, 1, 0); exp_cyc("j c1", 3'd1, 5'b00000);
        cyc(JMP, 1, 0); exp_cyc("j c2", 3'd2, 5'b01000);
        cyc(ADDI, 1, 0); exp_cyc("j next", 3'd0, 5'b11100);
        cyc(ADDI, 1, 0); cyc(ADDI, 1, 0); cyc(ADDI, 1, 0);

        // illegal opcode: absorbing TRAP for 20 cycles
        cyc(BAD, 1, 0); exp_cyc("bad c0", 3'd0, 5'b11100);
        cyc(BAD, 1, 0); exp_cyc("bad c1", 3'd1, 5'b00000);
        chk("bad illegal pre", {31'd0, illegal}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            cyc(ADDI, 1, 1); exp_cyc("trap", 3'd7, 5'b00000);
            chk("trap illegal", {31'd0, illegal}, 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_cyc("trap reset", 3'd0, 5'b00000);
        chk("trap reset illegal", {31'd0, illegal}, 32'd0);
        chk("trap reset ext_op", {30'd0, ext_op}, 32'd0);

        // illegal R-type funct
        cyc(BADF, 1, 0); exp_cyc("badf c0", 3'd0, 5'b11100);
        cyc(BADF, 1, 0); exp_cyc("badf c1", 3'd1, 5'b00000);
        cyc(BADF, 1, 0); exp_cyc("badf c2", 3'd7, 5'b00000);
        chk("badf illegal", {31'd0, illegal}, 32'd1);
        #2 rst_n = 1'b0;
        #1;

        // sw with reset asserted during a MEM stall
        cyc(SW, 1, 0); exp_cyc("swr c0", 3'd0, 5'b11100);
        cyc(SW, 1, 0); cyc(SW, 1, 0);
        cyc(SW, 0, 0); exp_cyc("swr c3", 3'd3, 5'b00010);
        #2 rst_n = 1'b0;
        #1;
        exp_cyc("swr reset", 3'd0, 5'b00000);
        chk("swr alu_ctl", {29'd0, alu_ctl}, 32'd2);
        chk("swr ext_op", {30'd0, ext_op}, 32'd0);
        cyc(ADDI, 1, 0); exp_cyc("post c0", 3'd0, 5'b11100);
        cyc(ADDI, 1, 0); exp_cyc("post c1", 3'd1, 5'b00000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
